// File: rtl/shift_register_driver_pkg.sv
// Shared types and default constants for the shift_register_driver slice.
package shift_register_driver_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SH_LO = 3'd1,
    ST_SH_HI = 3'd2,
    ST_LT_LO = 3'd3,
    ST_LT_HI = 3'd4
  } state_t;

endpackage

// File: rtl/shift_register_driver_clk_div_tick.sv
// Half-period timer: one-cycle tick every DIV cycles, restarted whenever the
// controller changes state.
module clk_div_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || tick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/shift_register_driver.sv
// Serialises one parallel word per handshake onto ser/srclk and strobes rclk.
// Optional readback of the cascade output is enabled by SR_DRIVER_READBACK_EN.
//
// state    | meaning
// IDLE     | in_ready high, waiting for a word
// SH_LO    | srclk low, current bit presented on ser
// SH_HI    | srclk high, ser held
// LT_LO    | all bits shifted, srclk/rclk low
// LT_HI    | rclk high, downstream latch updates
module shift_register_driver
  import shift_register_driver_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIV       = DEF_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser,
  output logic             srclk,
  output logic             rclk,
  output logic             busy,
  output logic             done
`ifdef SR_DRIVER_READBACK_EN
  ,
  input  logic             q7s,
  output logic [WIDTH-1:0] rd_data
`endif
);

  localparam int BW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [BW-1:0]    bits, bits_nxt;
  logic             tick;
  logic             accept;
  logic             cur_bit;

  assign accept = in_ready && in_valid;

  clk_div_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state_nxt != state),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    bits_nxt  = bits;
    case (state)
      ST_IDLE: if (accept) begin
        state_nxt = ST_SH_LO;
        sreg_nxt  = in_data;
        bits_nxt  = BW'(WIDTH);
      end
      ST_SH_LO: if (tick) state_nxt = ST_SH_HI;
      ST_SH_HI: if (tick) begin
        bits_nxt = bits - 1'b1;
        if (bits != BW'(1)) begin
          sreg_nxt  = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
          state_nxt = ST_SH_LO;
        end else begin
          state_nxt = ST_LT_LO;
        end
      end
      ST_LT_LO: if (tick) state_nxt = ST_LT_HI;
      ST_LT_HI: if (tick) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign cur_bit = MSB_FIRST ? sreg_nxt[WIDTH-1] : sreg_nxt[0];

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      bits     <= '0;
      in_ready <= 1'b0;
      ser      <= 1'b0;
      srclk    <= 1'b0;
      rclk     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      bits     <= bits_nxt;
      in_ready <= (state_nxt == ST_IDLE);
      ser      <= ((state_nxt == ST_SH_LO) || (state_nxt == ST_SH_HI)) ? cur_bit : 1'b0;
      srclk    <= (state_nxt == ST_SH_HI);
      rclk     <= (state_nxt == ST_LT_HI);
      busy     <= (state_nxt != ST_IDLE);
      done     <= (state == ST_LT_HI) && tick;
    end
  end

`ifdef SR_DRIVER_READBACK_EN
  logic [WIDTH-1:0] rb, rb_nxt;

  // Cascade bits land in the same positions they were transmitted from.
  always_comb begin
    rb_nxt = MSB_FIRST ? ((rb << 1) | WIDTH'(q7s))
                       : ((rb >> 1) | (WIDTH'(q7s) << (WIDTH - 1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rb      <= '0;
      rd_data <= '0;
    end else begin
      if ((state == ST_SH_HI) && tick) rb <= rb_nxt;
      if ((state == ST_LT_HI) && tick) rd_data <= rb;
    end
  end
`endif

endmodule

// File: doc/shift_register_driver.md
# shift_register_driver

- Upstream controller for the 8-bit serial-in/parallel-out `Shift_Register` stage.
- Accepts one parallel word per valid/ready handshake and clocks its bits out on `ser`, using a generated `srclk`.
- After the last bit it pulses `rclk` once, so the downstream output latch updates atomically.
- Everything runs off one system clock; `srclk` and `rclk` are registered strobes derived from it.

## Interface
- `WIDTH`, 8: bits per frame; must be ≥ 1.
- `DIV`, 1: half-period of `srclk`/`rclk` in `clk` cycles; must be ≥ 1.
- `MSB_FIRST`, 1: 1 sends bit `WIDTH-1` first, 0 sends bit 0 first.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  word to transmit.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word; high only in IDLE.
- `ser`  out  1  serial data to the downstream `s_in`.
- `srclk`  out  1  shift clock to the downstream `SRCLK`.
- `rclk`  out  1  latch clock to the downstream `RCLK`.
- `busy`  out  1  a frame is in progress (not IDLE).
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, SH_LO, SH_HI, LT_LO, LT_HI.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, load `in_data` into the shift register, set bit counter = `WIDTH`, go to SH_LO.
- SH_LO:
  - `srclk`=0 and `ser` = current bit (MSB or LSB per `MSB_FIRST`).
  - Stays `DIV` cycles, then goes to SH_HI.
- SH_HI:
  - `srclk`=1 for `DIV` cycles; `ser` is held.
  - On exit, decrement the counter.
  - If the counter is nonzero: shift the register, go to SH_LO.
  - Else: go to LT_LO.
- LT_LO: `srclk`=0, `rclk`=0 for `DIV` cycles, then LT_HI.
- LT_HI: `rclk`=1 for `DIV` cycles, then IDLE; `done`=1 in the first IDLE cycle.
- `in_valid` is ignored outside IDLE. `in_data` is captured only at accept and may change afterwards.
- Back-to-back: a word may be accepted in the same cycle `done` is high.
- Reset values: `ser`=0, `srclk`=0, `rclk`=0, `in_ready`=0 during reset and 1 in the first cycle after, `busy`=0, `done`=0.
- Reset mid-frame:
  - The frame is discarded and the next cycle is IDLE with all strobes low.
  - No `rclk` pulse is issued, so the downstream output latch keeps its previous word.
- The half-period counter is `$clog2(DIV+1)` bits wide and wraps to 0 at each state change.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Accept edge at cycle 0:
  - SH_LO starts at cycle 1, and `ser` is valid from cycle 1.
  - The first `srclk` rise is at cycle 1+`DIV`.
  - Bit k (k=0..WIDTH-1) rises at cycle 1+`DIV`+2·`DIV`·k.
- `rclk` rises at cycle 1+2·`DIV`·(`WIDTH`+1)−`DIV` and stays high for `DIV` cycles.
- `done` is at cycle 1+2·`DIV`·(`WIDTH`+1).
  - Default parameters: `rclk` high on cycle 18, `done` at cycle 19.
- `ser` setup to each `srclk` rise is `DIV` cycles; hold is `DIV` cycles.

## Configuration
- `SR_DRIVER_READBACK_EN`, when defined:
  - Adds port `q7s` in 1 (the downstream serial cascade output).
  - Adds port `rd_data` out WIDTH.
  - `q7s` is sampled on the last cycle of each SH_HI and shifted into a readback register in transmit order.
  - `rd_data` updates when `done` is asserted; its reset value is 0.
- Without the macro, neither port exists and no readback logic is built.

## Structure
- Package `shift_register_driver_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_SH_LO`, `ST_SH_HI`, `ST_LT_LO`, `ST_LT_HI`);
  - the default `WIDTH`/`DIV` constants.
- One sub-module, `clk_div_tick`: a counter emitting a one-cycle tick every `DIV` cycles, cleared on state change. The FSM and shifter stay in the top level.

## Test plan
- Defaults, send 8'hA5 → `ser` at the 8 `srclk` rises = 1,0,1,0,0,1,0,1.
  - Exactly one `rclk` pulse, at cycle 18; `done` at cycle 19.
  - A `Shift_Register` model's `p_out`=8'hA5 after the pulse.
- `MSB_FIRST`=0, `DIV`=3, send 8'h01:
  - First `ser` bit is 1, the rest 0.
  - `srclk` high/low phases are exactly 3 cycles each; `done` at cycle 55.
- Back-to-back 8'h3C then 8'hC3 with `in_valid` held high:
  - Second accept happens in the `done` cycle, with no idle gap.
  - The model's `p_out` shows 8'h3C, then 8'hC3.
- `in_valid` pulsed during busy with 8'hFF → ignored; frame data unchanged; `in_ready`=0 throughout.
- Assert `reset` at cycle 7 of a frame:
  - All outputs are 0 the next cycle and no `rclk` pulse occurs.
  - The model's `p_out` keeps its prior value; the next frame completes normally.
- With `SR_DRIVER_READBACK_EN`, chain model preloaded with 8'h5A, then send 8'h00 → `rd_data`=8'h5A when `done` is asserted.
